hdlc_receive_core: RTL and testbench

//  Serial HDLC frame receiver; the receive-side counterpart of the HDLC transmit core.

---
 rtl/hdlc_receive_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_hdlc_receive_core.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_receive_core.sv
// HDLC receiver: flag hunt, zero destuffing, LSB-first octet assembly,
// CRC-16/CCITT FCS check and a 2-octet delay line that strips the FCS.
module hdlc_receive_core #(
   parameter int unsigned MIN_BYTES   = 4,
   parameter logic [15:0] CRC_INIT    = 16'hFFFF,
   parameter logic [15:0] CRC_RESIDUE = 16'h1D0F
) (
   input  logic       Clk,
   input  logic       Rstn,
   input  logic       SRX,
   input  logic       RxEnable,
   output logic [7:0] RxData,
   output logic       RxValid,
   output logic       RxSOF,
   output logic       RxEOF,
   output logic       RxFcsOk,
   output logic       RxFcsErr,
   output logic       RxAbort,
   output logic       RxBusy,
   output logic       RxFlag
);

   typedef enum logic [1:0] {
      HUNT,
      SYNC,
      DATA
   } state_t;

   state_t      state_q, state_n;
   logic [7:0]  win_q, win_n;
   logic [2:0]  ones_q, ones_n;
   logic [2:0]  sones_q, sones_n;
   logic [3:0]  skip_q, skip_n;
   logic [7:0]  oct_q, oct_n;
   logic [2:0]  bitc_q, bitc_n;
   logic [15:0] crc_q, crc_n;
   logic [7:0]  bytes_q, bytes_n;
   logic [7:0]  p0_q, p0_n;
   logic [7:0]  p1_q, p1_n;
   logic [1:0]  pcnt_q, pcnt_n;
   logic        arm_q, arm_n;
   logic [7:0]  data_q, data_n;
   logic        valid_q, valid_n;
   logic        sofo_q, sofo_n;
   logic        eof_q, eof_n;
   logic        ok_q, ok_n;
   logic        err_q, err_n;
   logic        abort_q, abort_n;
   logic        flago_q, flago_n;

   logic [7:0]  win_sh;
   logic        flag_hit;
   logic        ab_hit;
   logic        dvalid;
   logic        dbit;
   logic        take;
   logic        done;
   logic [7:0]  oct_up;
   logic [15:0] crc_up;

   function automatic logic [15:0] crc_step(
      input logic [15:0] c,
      input logic        b
   );
      logic fb;
      fb = c[15] ^ b;
      return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   assign win_sh   = {SRX, win_q[7:1]};
   assign flag_hit = (win_sh == 8'h7E);
   assign ab_hit   = SRX && (ones_q == 3'd6);
   assign dvalid   = (skip_q == 4'd0);
   assign dbit     = win_q[0];
   // a zero after exactly five ones is a stuffed bit
   assign take     = dvalid && !(!dbit && sones_q == 3'd5);
   assign done     = (bitc_q == 3'd7);
   assign oct_up   = {dbit, oct_q[7:1]};
   assign crc_up   = crc_step(crc_q, dbit);

   always_ff @(posedge Clk) begin
      if (!Rstn) begin
         state_q <= HUNT;
         win_q   <= 8'hFF;
         ones_q  <= 3'd0;
         sones_q <= 3'd0;
         skip_q  <= 4'd0;
         oct_q   <= 8'h00;
         bitc_q  <= 3'd0;
         crc_q   <= CRC_INIT;
         bytes_q <= 8'h00;
         p0_q    <= 8'h00;
         p1_q    <= 8'h00;
         pcnt_q  <= 2'd0;
         arm_q   <= 1'b1;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         sofo_q  <= 1'b0;
         eof_q   <= 1'b0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         flago_q <= 1'b0;
      end else begin
         state_q <= state_n;
         win_q   <= win_n;
         ones_q  <= ones_n;
         sones_q <= sones_n;
         skip_q  <= skip_n;
         oct_q   <= oct_n;
         bitc_q  <= bitc_n;
         crc_q   <= crc_n;
         bytes_q <= bytes_n;
         p0_q    <= p0_n;
         p1_q    <= p1_n;
         pcnt_q  <= pcnt_n;
         arm_q   <= arm_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         sofo_q  <= sofo_n;
         eof_q   <= eof_n;
         ok_q    <= ok_n;
         err_q   <= err_n;
         abort_q <= abort_n;
         flago_q <= flago_n;
      end
   end

   always_comb begin
      state_n = state_q;
      win_n   = win_q;
      ones_n  = ones_q;
      sones_n = sones_q;
      skip_n  = skip_q;
      oct_n   = oct_q;
      bitc_n  = bitc_q;
      crc_n   = crc_q;
      bytes_n = bytes_q;
      p0_n    = p0_q;
      p1_n    = p1_q;
      pcnt_n  = pcnt_q;
      arm_n   = arm_q;
      data_n  = data_q;
      valid_n = 1'b0;
      sofo_n  = 1'b0;
      eof_n   = 1'b0;
      ok_n    = 1'b0;
      err_n   = 1'b0;
      abort_n = 1'b0;
      flago_n = 1'b0;
      if (RxEnable) begin
         win_n   = win_sh;
         flago_n = flag_hit;
         if (!SRX)
            ones_n = 3'd0;
         else if (ones_q != 3'd7)
            ones_n = ones_q + 3'd1;
         // the flag's own bits drain out of the window unprocessed
         if (flag_hit)
            skip_n = 4'd8;
         else if (!dvalid)
            skip_n = skip_q - 4'd1;
         if (!dvalid || !dbit)
            sones_n = 3'd0;
         else if (sones_q != 3'd7)
            sones_n = sones_q + 3'd1;
         if (state_q != HUNT && take && !ab_hit &&
             !(state_q == SYNC && flag_hit)) begin
            oct_n  = oct_up;
            bitc_n = bitc_q + 3'd1;
            crc_n  = crc_up;
            if (state_q == SYNC)
               state_n = DATA;
            if (done) begin
               if (bytes_q != 8'hFF)
                  bytes_n = bytes_q + 8'd1;
               if (pcnt_q == 2'd2) begin
                  valid_n = 1'b1;
                  data_n  = p0_q;
                  sofo_n  = arm_q;
                  arm_n   = 1'b0;
                  p0_n    = p1_q;
                  p1_n    = oct_up;
               end else if (pcnt_q == 2'd1) begin
                  p1_n   = oct_up;
                  pcnt_n = 2'd2;
               end else begin
                  p0_n   = oct_up;
                  pcnt_n = 2'd1;
               end
            end
         end
         unique case (state_q)
            HUNT: begin
               if (flag_hit)
                  state_n = SYNC;
            end
            SYNC: begin
               if (ab_hit)
                  state_n = HUNT;
               else if (flag_hit)
                  state_n = SYNC;
            end
            DATA: begin
               if (ab_hit) begin
                  state_n = HUNT;
                  eof_n   = 1'b1;
                  abort_n = 1'b1;
               end else if (flag_hit) begin
                  state_n = SYNC;
                  eof_n   = 1'b1;
                  ok_n    = (bitc_n == 3'd0) &&
                            (32'(bytes_n) >= MIN_BYTES) &&
                            (crc_n == CRC_RESIDUE);
                  err_n   = !ok_n;
               end
            end
            default: state_n = HUNT;
         endcase
         if (state_n != DATA) begin
            crc_n   = CRC_INIT;
            bitc_n  = 3'd0;
            bytes_n = 8'h00;
            pcnt_n  = 2'd0;
            arm_n   = 1'b1;
         end
      end
   end

   assign RxData   = data_q;
   assign RxValid  = valid_q;
   assign RxSOF    = sofo_q;
   assign RxEOF    = eof_q;
   assign RxFcsOk  = ok_q;
   assign RxFcsErr = err_q;
   assign RxAbort  = abort_q;
   assign RxFlag   = flago_q;
   assign RxBusy   = (state_q == DATA);

endmodule

// File: tb/tb_hdlc_receive_core.sv
// Directed bench for hdlc_receive_core: frames are built with bit
// stuffing and an X.25 FCS computed here, results are scoreboarded.
module tb_hdlc_receive_core;

   logic       Clk;
   logic       Rstn;
   logic       SRX;
   logic       RxEnable;
   logic [7:0] RxData;
   logic       RxValid;
   logic       RxSOF;
   logic       RxEOF;
   logic       RxFcsOk;
   logic       RxFcsErr;
   logic       RxAbort;
   logic       RxBusy;
   logic       RxFlag;

   hdlc_receive_core dut (
      .Clk      (Clk),
      .Rstn     (Rstn),
      .SRX      (SRX),
      .RxEnable (RxEnable),
      .RxData   (RxData),
      .RxValid  (RxValid),
      .RxSOF    (RxSOF),
      .RxEOF    (RxEOF),
      .RxFcsOk  (RxFcsOk),
      .RxFcsErr (RxFcsErr),
      .RxAbort  (RxAbort),
      .RxBusy   (RxBusy),
      .RxFlag   (RxFlag)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]   rx_q[$];
   logic         rx_sof_q[$];
   int           n_eof, n_ok, n_err, n_abort, n_flag;
   byte unsigned pay_q[$];
   logic [7:0]   exp_q[$];
   logic         exp_sof_q[$];
   int           tx_ones;

   always @(negedge Clk) begin
      if (RxValid) begin
         rx_q.push_back(RxData);
         rx_sof_q.push_back(RxSOF);
      end
      if (RxEOF) begin
         n_eof++;
         if (RxFcsOk)  n_ok++;
         if (RxFcsErr) n_err++;
         if (RxAbort)  n_abort++;
      end
      if (RxFlag) n_flag++;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_sb();
      rx_q.delete();
      rx_sof_q.delete();
      exp_q.delete();
      exp_sof_q.delete();
      n_eof   = 0;
      n_ok    = 0;
      n_err   = 0;
      n_abort = 0;
      n_flag  = 0;
   endtask

   task automatic expect_bytes(input logic [7:0] b[$]);
      foreach (b[i]) begin
         exp_q.push_back(b[i]);
         exp_sof_q.push_back(i == 0);
      end
   endtask

   task automatic send_bit(input logic b, input int gap);
      SRX      = b;
      RxEnable = 1'b1;
      @(negedge Clk);
      RxEnable = 1'b0;
      repeat (gap) @(negedge Clk);
   endtask

   task automatic send_ones(input int n, input int gap);
      for (int i = 0; i < n; i++) send_bit(1'b1, gap);
   endtask

   task automatic send_flag(input int gap);
      logic [7:0] f;
      f = 8'h7E;
      for (int i = 0; i < 8; i++) send_bit(f[i], gap);
      tx_ones = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int i = 0; i < 8; i++) begin
         send_bit(b[i], gap);
         tx_ones = b[i] ? tx_ones + 1 : 0;
         if (tx_ones == 5) begin
            send_bit(1'b0, gap);
            tx_ones = 0;
         end
      end
   endtask

   // X.25 FCS (reflected 0x8408), low octet sent first
   task automatic send_frame(input int gap, input bit flip);
      logic [15:0] r;
      logic [7:0]  b;
      logic        fb;
      r = 16'hFFFF;
      foreach (pay_q[k]) begin
         b = pay_q[k];
         for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 16'h8408;
         end
      end
      r = ~r;
      foreach (pay_q[k]) begin
         b = pay_q[k];
         if (flip && k == 1) b = b ^ 8'h08;
         send_byte(b, gap);
      end
      send_byte(r[7:0], gap);
      send_byte(r[15:8], gap);
   endtask

   task automatic check_frame(input string tag, input int ev,
                              input int ok, input int err,
                              input int ab);
      logic [31:0] obs;
      check({tag, "_nvalid"}, rx_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         obs = (i < rx_q.size()) ? {23'd0, rx_sof_q[i], rx_q[i]}
                                 : 32'hDEAD;
         check($sformatf("%s_byte%0d", tag, i), obs,
               {23'd0, exp_sof_q[i], exp_q[i]});
      end
      check({tag, "_eof"}, n_eof, ev);
      check({tag, "_ok"}, n_ok, ok);
      check({tag, "_err"}, n_err, err);
      check({tag, "_abort"}, n_abort, ab);
   endtask

   initial begin
      Rstn     = 1'b0;
      SRX      = 1'b1;
      RxEnable = 1'b0;
      tx_ones  = 0;
      clear_sb();
      repeat (3) @(negedge Clk);
      check("reset_outs",
            {RxData, RxValid, RxSOF, RxEOF, RxFcsOk,
             RxFcsErr, RxAbort, RxBusy, RxFlag}, 0);
      Rstn = 1'b1;
      @(negedge Clk);
      check("reset_busy", RxBusy, 0);

      // good frame 01 02 03
      send_ones(16, 0);
      send_flag(0);
      pay_q = '{8'h01, 8'h02, 8'h03};
      send_frame(0, 1'b0);
      send_flag(0);
      send_ones(10, 0);
      repeat (4) @(negedge Clk);
      expect_bytes('{8'h01, 8'h02, 8'h03});
      check_frame("good", 1, 1, 0, 0);
      check("good_idle_busy", RxBusy, 0);

      // one payload bit flipped
      clear_sb();
      send_flag(0);
      send_frame(0, 1'b1);
      send_flag(0);
      send_ones(10, 0);
      repeat (4) @(negedge Clk);
      expect_bytes('{8'h01, 8'h0A, 8'h03});
      check_frame("bad", 1, 0, 1, 0);

      // stuffing-heavy payload
      clear_sb();
      send_flag(0);
      pay_q = '{8'hFF, 8'h1F};
      send_frame(0, 1'b0);
      send_flag(0);
      send_ones(10, 0);
      repeat (4) @(negedge Clk);
      expect_bytes('{8'hFF, 8'h1F});
      check_frame("stuff", 1, 1, 0, 0);

      // repeated flags, shared flag between two frames
      clear_sb();
      send_flag(0);
      send_flag(0);
      send_flag(0);
      pay_q = '{8'hA5, 8'h5A, 8'h3C};
      send_frame(0, 1'b0);
      send_flag(0);
      pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_frame(0, 1'b0);
      send_flag(0);
      send_ones(10, 0);
      repeat (4) @(negedge Clk);
      expect_bytes('{8'hA5, 8'h5A, 8'h3C});
      expect_bytes('{8'h11, 8'h22, 8'h33, 8'h44});
      check_frame("shared", 2, 2, 0, 0);
      check("shared_flags", n_flag, 5);

      // abort mid-payload
      clear_sb();
      send_flag(0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      check("abort_busy_mid", RxBusy, 1);
      send_ones(8, 0);
      send_ones(4, 0);
      repeat (4) @(negedge Clk);
      check_frame("abort", 1, 0, 0, 1);
      check("abort_busy", RxBusy, 0);

      // body without opening flag is ignored
      clear_sb();
      pay_q = '{8'h05, 8'h06, 8'h07};
      send_frame(0, 1'b0);
      send_flag(0);
      send_ones(10, 0);
      repeat (4) @(negedge Clk);
      check("noopen_eof", n_eof, 0);
      send_flag(0);
      send_frame(0, 1'b0);
      send_flag(0);
      send_ones(10, 0);
      repeat (4) @(negedge Clk);
      expect_bytes('{8'h05, 8'h06, 8'h07});
      check_frame("reopen", 1, 1, 0, 0);

      // short frame with enable gaps
      clear_sb();
      send_flag(3);
      send_byte(8'h12, 3);
      send_byte(8'h34, 3);
      send_flag(3);
      send_ones(10, 3);
      repeat (4) @(negedge Clk);
      check_frame("short", 1, 0, 1, 0);

      // good frame with enable gaps
      clear_sb();
      send_flag(3);
      pay_q = '{8'h01, 8'h02, 8'h03};
      send_frame(3, 1'b0);
      send_flag(3);
      send_ones(10, 3);
      repeat (4) @(negedge Clk);
      expect_bytes('{8'h01, 8'h02, 8'h03});
      check_frame("gap", 1, 1, 0, 0);

      // reset mid-frame
      clear_sb();
      send_flag(0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      Rstn = 1'b0;
      repeat (2) @(negedge Clk);
      Rstn = 1'b1;
      @(negedge Clk);
      check("rst_busy", RxBusy, 0);
      send_byte(8'h03, 0);
      send_ones(10, 0);
      repeat (4) @(negedge Clk);
      check("rst_eof", n_eof, 0);
      check("rst_valid", rx_q.size(), 0);
      send_flag(0);
      pay_q = '{8'hC3, 8'h3C, 8'h81};
      send_frame(0, 1'b0);
      send_flag(0);
      send_ones(10, 0);
      repeat (4) @(negedge Clk);
      expect_bytes('{8'hC3, 8'h3C, 8'h81});
      check_frame("postrst", 1, 1, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
